// File: rtl/wb_stage.sv
// Write-back stage: latches the mem->wb bus, commits RF/CSR writes, raises exception/ERTN flushes.
// One cycle from the mem handshake to the RF write; never stalls (wb_allowin is tied to 1).
module wb_stage (
  input  logic         clk,
  input  logic         reset,
  input  logic         mem_wb_valid,
  output logic         wb_allowin,
  input  logic [231:0] mem_wb_bus,
  output logic         rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic [37:0]  wb_id_bus,
  output logic         wb_ex,
  output logic         ertn_flush,
  output logic [31:0]  ex_entry,
  output logic [31:0]  ertn_pc,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_we,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);

  typedef struct packed {
    logic        gr_we;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] final_result;
    logic [4:0]  dest;
    logic        csr_we;
    logic        csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        ertn;
    logic        syscall_ex;
    logic [31:0] wrong_addr;
    logic        ex;
    logic [8:0]  esubcode;
    logic [5:0]  ecode;
  } mem_wb_t;

  localparam logic [13:0] CSR_CRMD   = 14'h00;
  localparam logic [13:0] CSR_PRMD   = 14'h01;
  localparam logic [13:0] CSR_ESTAT  = 14'h05;
  localparam logic [13:0] CSR_ERA    = 14'h06;
  localparam logic [13:0] CSR_BADV   = 14'h07;
  localparam logic [13:0] CSR_EENTRY = 14'h0C;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;

  logic        wb_valid_q, wb_valid_d;
  mem_wb_t     bus_q, bus_d;

  logic [1:0]  crmd_plv_q, crmd_plv_d;
  logic        crmd_ie_q, crmd_ie_d;
  logic [1:0]  prmd_pplv_q, prmd_pplv_d;
  logic        prmd_pie_q, prmd_pie_d;
  logic [1:0]  estat_is_q, estat_is_d;
  logic [5:0]  estat_ecode_q, estat_ecode_d;
  logic [8:0]  estat_esub_q, estat_esub_d;
  logic [31:0] era_q, era_d;
  logic [31:0] badv_q, badv_d;
  logic [25:0] eentry_va_q, eentry_va_d;
  logic [31:0] save0_q, save0_d, save1_q, save1_d, save2_q, save2_d, save3_q, save3_d;

  logic [31:0] csr_rdata;
  logic [31:0] csr_wr_data;
  logic        csr_wen;
  logic        unused_bits;

  assign wb_allowin = 1'b1;
  assign unused_bits = ^{bus_q.inst, bus_q.syscall_ex};

  always_comb begin
    wb_valid_d = wb_valid_q;
    if (wb_allowin) wb_valid_d = mem_wb_valid;
    bus_d = bus_q;
    if (mem_wb_valid && wb_allowin) bus_d = mem_wb_t'(mem_wb_bus);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wb_valid_q <= 1'b0;
    else       wb_valid_q <= wb_valid_d;
  end

  // Bus contents are intentionally not reset so debug_wb_pc keeps its last value.
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  always_comb begin
    csr_rdata = 32'h0;
    case (bus_q.csr_num)
      CSR_CRMD:   csr_rdata = {28'h0, 1'b1, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   csr_rdata = {29'h0, prmd_pie_q, prmd_pplv_q};
      CSR_ESTAT:  csr_rdata = {1'b0, estat_esub_q, estat_ecode_q, 14'h0, estat_is_q};
      CSR_ERA:    csr_rdata = era_q;
      CSR_BADV:   csr_rdata = badv_q;
      CSR_EENTRY: csr_rdata = {eentry_va_q, 6'h0};
      CSR_SAVE0:  csr_rdata = save0_q;
      CSR_SAVE1:  csr_rdata = save1_q;
      CSR_SAVE2:  csr_rdata = save2_q;
      CSR_SAVE3:  csr_rdata = save3_q;
      default:    csr_rdata = 32'h0;
    endcase
  end

  assign rf_we      = wb_valid_q & bus_q.gr_we & ~bus_q.ex;
  assign csr_wen    = wb_valid_q & bus_q.csr_we & ~bus_q.ex & ~bus_q.ertn;
  assign wb_ex      = wb_valid_q & bus_q.ex;
  assign ertn_flush = wb_valid_q & bus_q.ertn & ~bus_q.ex;
  assign csr_wr_data = (csr_rdata & ~bus_q.csr_wmask) | (bus_q.csr_wvalue & bus_q.csr_wmask);

  // csr_wen, wb_ex and ertn_flush are mutually exclusive, so their order here is immaterial.
  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    estat_is_d    = estat_is_q;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    badv_d        = badv_q;
    eentry_va_d   = eentry_va_q;
    save0_d       = save0_q;
    save1_d       = save1_q;
    save2_d       = save2_q;
    save3_d       = save3_q;
    if (csr_wen) begin
      case (bus_q.csr_num)
        CSR_CRMD:   begin crmd_plv_d = csr_wr_data[1:0]; crmd_ie_d = csr_wr_data[2]; end
        CSR_PRMD:   begin prmd_pplv_d = csr_wr_data[1:0]; prmd_pie_d = csr_wr_data[2]; end
        CSR_ESTAT:  estat_is_d  = csr_wr_data[1:0];
        CSR_ERA:    era_d       = csr_wr_data;
        CSR_BADV:   badv_d      = csr_wr_data;
        CSR_EENTRY: eentry_va_d = csr_wr_data[31:6];
        CSR_SAVE0:  save0_d     = csr_wr_data;
        CSR_SAVE1:  save1_d     = csr_wr_data;
        CSR_SAVE2:  save2_d     = csr_wr_data;
        CSR_SAVE3:  save3_d     = csr_wr_data;
        default:    ;
      endcase
    end
    if (wb_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'b00;
      crmd_ie_d     = 1'b0;
      estat_ecode_d = bus_q.ecode;
      estat_esub_d  = bus_q.esubcode;
      era_d         = bus_q.pc;
      if (bus_q.ecode == 6'h08 || bus_q.ecode == 6'h09) badv_d = bus_q.wrong_addr;
    end
    if (ertn_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_plv_q    <= 2'b00;
      crmd_ie_q     <= 1'b0;
      prmd_pplv_q   <= 2'b00;
      prmd_pie_q    <= 1'b0;
      estat_is_q    <= 2'b00;
      estat_ecode_q <= 6'h0;
      estat_esub_q  <= 9'h0;
      era_q         <= 32'h0;
      badv_q        <= 32'h0;
      eentry_va_q   <= 26'h0;
      save0_q       <= 32'h0;
      save1_q       <= 32'h0;
      save2_q       <= 32'h0;
      save3_q       <= 32'h0;
    end else begin
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      estat_is_q    <= estat_is_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      badv_q        <= badv_d;
      eentry_va_q   <= eentry_va_d;
      save0_q       <= save0_d;
      save1_q       <= save1_d;
      save2_q       <= save2_d;
      save3_q       <= save3_d;
    end
  end

  assign rf_waddr          = bus_q.dest;
  assign rf_wdata          = bus_q.csr_re ? csr_rdata : bus_q.final_result;
  assign wb_id_bus         = {wb_valid_q & bus_q.gr_we, rf_waddr, rf_wdata};
  assign ex_entry          = {eentry_va_q, 6'h0};
  assign ertn_pc           = era_q;
  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_we    = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
